silife_loader_master: RTL and testbench
=======================================

Name: silife_loader_master

Overview:
- SPI master that drives the grid-loader SPI port of a neighbouring silife chip (CS, CLK, DIN, DOUT) from an on-chip host, enabling chained multi-chip grid load and readback.
- Host supplies 32-bit row words on a valid/ready stream; each word is shifted out MSB-first while the slave's DOUT is captured into a returned 32-bit word.
- Sits beside the silife core in the user project; outputs go to IO pads, DOUT comes from a pad through an internal synchronizer.

Parameters:
- CLK_DIV, 4, clk cycles per SCK phase (high or low); legal range 3..255.
- WORD_BITS, 32, bits per transferred word (one grid row).
- CNT_W, 6, width of the word-count input.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- i_start  input  1  one-cycle pulse; begins a frame when idle
- i_num_words  input  CNT_W  words in frame, sampled on accepted i_start
- i_tx_data  input  WORD_BITS  word to shift out
- i_tx_valid  input  1  i_tx_data valid
- o_tx_ready  output  1  word accepted this cycle (valid&ready)
- o_rx_data  output  WORD_BITS  captured word from slave DOUT
- o_rx_valid  output  1  one-cycle pulse, o_rx_data valid
- o_busy  output  1  frame in progress
- o_done  output  1  one-cycle pulse at frame end
- o_load_cs  output  1  slave chip select, active low
- o_load_clk  output  1  SCK, idle low
- o_load_din  output  1  MOSI to slave
- i_load_dout  input  1  MISO from slave (asynchronous to clk)

Behaviour:
- Reset (async, any state): o_load_cs=1, o_load_clk=0, o_load_din=0, o_busy=0, o_done=0, o_rx_valid=0, o_tx_ready=0, o_rx_data=0; FSM->IDLE; any in-progress frame aborted with no o_done.
- SPI mode 0: DIN changes while SCK low, slave samples on SCK rise; MSB first.
- i_load_dout passes through a 2-flop synchronizer; master samples the synchronized value on the last clk of each SCK-high phase (needs CLK_DIV>=3, covering synchronizer latency).
- FSM states: IDLE, LOAD, LOW, HIGH, FINISH.
- IDLE: i_start with i_num_words!=0 -> latch count, o_busy=1, o_load_cs=0, go LOAD. i_start with count 0 -> ignored, no o_done. i_start while busy -> ignored.
- LOAD: o_tx_ready = i_tx_valid; on handshake, load shift register, drive MSB on o_load_din, clear bit counter, go LOW. Without valid: stall with CS low, SCK low, DIN held.
- LOW: SCK=0 for CLK_DIV cycles -> HIGH.
- HIGH: SCK=1 for CLK_DIV cycles; on last cycle shift synchronized DOUT into rx register LSB, tx register shifts left. If bit counter < WORD_BITS-1: increment, drive next bit, -> LOW. Else word complete: o_rx_valid pulses with full word the next cycle; decrement word count; if remaining>0 -> LOAD, else -> FINISH.
- FINISH: hold SCK low, CS low for CLK_DIV cycles, then CS=1, o_done pulse same cycle as CS rise, o_busy=0, -> IDLE. i_start on the o_done cycle is ignored; accepted from the following cycle.
- Per-word SCK time = 2*CLK_DIV*WORD_BITS clk cycles, plus >=1 LOAD cycle per word; CS low from first LOAD through FINISH.
- Word counter is CNT_W bits, no wrap: max frame 2^CNT_W-1 words.
- o_tx_ready is asserted only in LOAD and only with i_tx_valid.

Test Plan:
- Single word, CLK_DIV=4: i_num_words=1, tx=0xA5A5_0F0F, slave loopback DOUT=DIN -> 32 SCK rises, DIN bits MSB-first match; o_rx_data=0xA5A5_0F0F (plus synchronizer-latency-correct bit alignment per model), o_rx_valid once, o_done once, CS low for exactly 1+256+4 cycles.
- Multi-word: 3 words 0x1, 0x8000_0000, 0xFFFF_FFFF, slave model returns 0xDEAD_BEEF each -> three o_rx_valid pulses each 0xDEAD_BEEF, three o_tx_ready pulses, CS stays low between words, one o_done.
- Backpressure: i_tx_valid low 20 cycles between words 1 and 2 -> SCK static low, CS low, no extra SCK edges; transfer resumes, data intact.
- Ignored starts: i_start with count 0 -> o_busy stays 0, no CS activity; i_start mid-frame -> frame length unchanged.
- Reset mid-word: assert reset after 10 SCK rises -> same cycle CS=1, SCK=0, DIN=0, o_busy=0; no o_done/o_rx_valid; fresh 1-word frame afterwards correct.
- CLK_DIV=3 corner: 1-word frame with slave shifting 0x1234_5678 -> o_rx_data=0x1234_5678, SCK high/low phases exactly 3 cycles.

Source files
------------

// File: rtl/silife_loader_master_if.sv
// Host-side word stream and frame status of the grid-loader SPI master.
interface silife_loader_master_if #(
    parameter int WORD_BITS = 32,
    parameter int CNT_W     = 6
);
    // A tx word transfers on a cycle where i_tx_valid and o_tx_ready are both high;
    // the host holds i_tx_data stable while i_tx_valid waits. o_rx_valid and o_done
    // are single-cycle pulses with no back-pressure.
    logic                 i_start;
    logic [CNT_W-1:0]     i_num_words;
    logic [WORD_BITS-1:0] i_tx_data;
    logic                 i_tx_valid;
    logic                 o_tx_ready;
    logic [WORD_BITS-1:0] o_rx_data;
    logic                 o_rx_valid;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        output i_start, i_num_words, i_tx_data, i_tx_valid,
        input  o_tx_ready, o_rx_data, o_rx_valid, o_busy, o_done
    );

    modport slave (
        input  i_start, i_num_words, i_tx_data, i_tx_valid,
        output o_tx_ready, o_rx_data, o_rx_valid, o_busy, o_done
    );
endinterface

// File: rtl/silife_loader_master.sv
// SPI mode-0 master driving the grid-loader port of a neighbouring silife chip:
// host words shift out MSB-first while the slave's DOUT is captured into rx words.
module silife_loader_master #(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = 32,
    parameter int CNT_W     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    silife_loader_master_if.slave host,
    output logic                  o_load_cs,
    output logic                  o_load_clk,
    output logic                  o_load_din,
    input  logic                  i_load_dout,
    output logic [2:0]            o_dbg_state
);
    localparam int BIT_W = $clog2(WORD_BITS);
    localparam int DIV_W = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_LOW    = 3'd2;
    localparam logic [2:0] S_HIGH   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]           state_q,    state_d;
    logic [DIV_W-1:0]     div_cnt_q,  div_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [CNT_W-1:0]     words_q,    words_d;
    logic [WORD_BITS-2:0] tx_sh_q,    tx_sh_d;
    logic [WORD_BITS-2:0] rx_sh_q,    rx_sh_d;
    logic [WORD_BITS-1:0] rx_data_q,  rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 done_q,     done_d;
    logic                 busy_q,     busy_d;
    logic                 cs_q,       cs_d;
    logic                 sck_q,      sck_d;
    logic                 din_q,      din_d;
    logic                 sync1_q,    sync1_d;
    logic                 sync2_q,    sync2_d;
    logic                 div_last;
    logic                 tx_ready;

    assign div_last = (div_cnt_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        words_d    = words_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;
        cs_d       = cs_q;
        sck_d      = sck_q;
        din_d      = din_q;
        tx_ready   = 1'b0;
        // DOUT is asynchronous to clk; only sync2_q is ever sampled.
        sync1_d    = i_load_dout;
        sync2_d    = sync1_q;

        case (state_q)
            S_IDLE: begin
                // The o_done cycle itself refuses a new start.
                if (host.i_start && !done_q && (host.i_num_words != '0)) begin
                    words_d = host.i_num_words;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_ready = host.i_tx_valid;
                if (host.i_tx_valid) begin
                    din_d     = host.i_tx_data[WORD_BITS-1];
                    tx_sh_d   = host.i_tx_data[WORD_BITS-2:0];
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = S_LOW;
                end
            end
            S_LOW: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    sck_d     = 1'b1;
                    state_d   = S_HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_HIGH: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    sck_d     = 1'b0;
                    rx_sh_d   = {rx_sh_q[WORD_BITS-3:0], sync2_q};
                    tx_sh_d   = {tx_sh_q[WORD_BITS-3:0], 1'b0};
                    if (bit_cnt_q != BIT_W'(WORD_BITS - 1)) begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        din_d     = tx_sh_q[WORD_BITS-2];
                        state_d   = S_LOW;
                    end else begin
                        rx_data_d  = {rx_sh_q, sync2_q};
                        rx_valid_d = 1'b1;
                        words_d    = words_q - CNT_W'(1);
                        state_d    = (words_q == CNT_W'(1)) ? S_FINISH : S_LOAD;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_FINISH: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    cs_d      = 1'b1;
                    din_d     = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            words_q    <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            din_q      <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            words_q    <= words_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            cs_q       <= cs_d;
            sck_q      <= sck_d;
            din_q      <= din_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

    assign host.o_tx_ready = tx_ready;
    assign host.o_rx_data  = rx_data_q;
    assign host.o_rx_valid = rx_valid_q;
    assign host.o_busy     = busy_q;
    assign host.o_done     = done_q;
    assign o_load_cs       = cs_q;
    assign o_load_clk      = sck_q;
    assign o_load_din      = din_q;
    assign o_dbg_state     = state_q;
endmodule

// File: tb/tb_silife_loader_master.sv
// Bench for silife_loader_master: a CLK_DIV=4 instance under random and directed
// frames against an SPI slave model, plus a CLK_DIV=3 corner instance.
module tb_silife_loader_master;
  localparam int WB   = 32;
  localparam int CW   = 6;
  localparam int DIV  = 4;
  localparam int DIV3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  silife_loader_master_if #(.WORD_BITS(WB), .CNT_W(CW)) hif ();
  silife_loader_master_if #(.WORD_BITS(WB), .CNT_W(CW)) hif3 ();

  logic       cs, sck, din, dout;
  logic       cs3, sck3, din3, dout3;
  logic [2:0] dbg, dbg3;

  silife_loader_master #(.CLK_DIV(DIV), .WORD_BITS(WB), .CNT_W(CW)) dut (
    .clk(clk), .reset(rst), .host(hif.slave),
    .o_load_cs(cs), .o_load_clk(sck), .o_load_din(din), .i_load_dout(dout),
    .o_dbg_state(dbg)
  );

  silife_loader_master #(.CLK_DIV(DIV3), .WORD_BITS(WB), .CNT_W(CW)) dut3 (
    .clk(clk), .reset(rst), .host(hif3.slave),
    .o_load_cs(cs3), .o_load_clk(sck3), .o_load_din(din3), .i_load_dout(dout3),
    .o_dbg_state(dbg3)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- SPI slave models ----------------
  // Slave drives bit (31 - n%32) of word n/32 after its n-th SCK fall in the frame.
  logic        loopback = 1'b1;
  logic [31:0] slave_words [64];
  logic [31:0] tx_words [64];
  logic [10:0] fall_cnt = '0;
  logic        prev_sck_s = 1'b0;
  logic        slave_bit;

  always @(negedge clk) begin
    if (cs) fall_cnt = '0;
    else if (prev_sck_s && !sck) fall_cnt = fall_cnt + 11'd1;
    prev_sck_s = sck;
  end
  assign slave_bit = slave_words[fall_cnt[10:5]][5'd31 - fall_cnt[4:0]];
  assign dout      = loopback ? din : slave_bit;

  logic [31:0] slave3_word = 32'h1234_5678;
  logic [10:0] fall3 = '0;
  logic        prev_sck3_s = 1'b0;
  always @(negedge clk) begin
    if (cs3) fall3 = '0;
    else if (prev_sck3_s && !sck3) fall3 = fall3 + 11'd1;
    prev_sck3_s = sck3;
  end
  assign dout3 = slave3_word[5'd31 - fall3[4:0]];

  // ---------------- scoreboard / monitors ----------------
  logic [WB-1:0] exp_q[$];
  logic          exp_bit_q[$];
  logic [WB-1:0] exp3_q[$];

  int rxv_cnt = 0, txr_cnt = 0, done_cnt = 0, rise_cnt = 0, cs_low_cnt = 0;
  int high_len = 0, low_len = 0, bit_in_word = 0;
  logic prev_sck_m = 1'b0, prev_cs_m = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      high_len = 0; low_len = 0; bit_in_word = 0;
      prev_sck_m = 1'b0; prev_cs_m = 1'b1;
    end else begin
      if (hif.o_rx_valid) begin
        rxv_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected: got %h, nothing expected", hif.o_rx_data);
        end else chk("rx_data", hif.o_rx_data, exp_q.pop_front());
      end
      if (hif.o_tx_ready) txr_cnt++;
      if (hif.o_done) begin
        done_cnt++;
        chk("done_on_cs_rise", {30'd0, cs, prev_cs_m}, 32'd2);
      end
      if (!cs) cs_low_cnt++;
      if (sck && !prev_sck_m) begin
        rise_cnt++;
        if (bit_in_word != 0) chk("sck_low_len", low_len, DIV);
        bit_in_word = (bit_in_word + 1) % WB;
        high_len = 1;
        if (exp_bit_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL din_unexpected: got SCK rise with din=%0b, no bit expected", din);
        end else chk("din_bit", din, exp_bit_q.pop_front());
      end else if (sck) begin
        high_len++;
      end else if (prev_sck_m) begin
        chk("sck_high_len", high_len, DIV);
        low_len = 1;
      end else begin
        low_len++;
      end
      if (cs) bit_in_word = 0;
      prev_sck_m = sck;
      prev_cs_m  = cs;
    end
  end

  int high3 = 0, low3 = 0, bit3 = 0, cs3_low = 0;
  logic prev_sck3_m = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      high3 = 0; low3 = 0; bit3 = 0; prev_sck3_m = 1'b0;
    end else begin
      if (hif3.o_rx_valid) begin
        if (exp3_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL div3_rx_unexpected: got %h, nothing expected", hif3.o_rx_data);
        end else chk("div3_rx_data", hif3.o_rx_data, exp3_q.pop_front());
      end
      if (!cs3) cs3_low++;
      if (sck3 && !prev_sck3_m) begin
        if (bit3 != 0) chk("div3_low_len", low3, DIV3);
        bit3 = (bit3 + 1) % WB;
        high3 = 1;
      end else if (sck3) begin
        high3++;
      end else if (prev_sck3_m) begin
        chk("div3_high_len", high3, DIV3);
        low3 = 1;
      end else begin
        low3++;
      end
      if (cs3) bit3 = 0;
      prev_sck3_m = sck3;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_pulse(input logic [CW-1:0] n);
    hif.i_start = 1'b1;
    hif.i_num_words = n;
    @(posedge clk); #1;
    hif.i_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] rx_exp);
    int t = 0;
    bit ok = 0;
    hif.i_tx_data = w;
    hif.i_tx_valid = 1'b1;
    while (t < 5000) begin
      @(negedge clk);
      if (hif.o_tx_ready) begin ok = 1; break; end
      t++;
    end
    if (ok) begin
      exp_q.push_back(rx_exp);
      for (int b = WB - 1; b >= 0; b--) exp_bit_q.push_back(w[b]);
    end else begin
      checks++; errors++;
      $display("FAIL tx_ready_timeout: got no o_tx_ready, required one within 5000 cycles");
    end
    @(posedge clk); #1;
    hif.i_tx_valid = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit lb, input int gap_word, input int gap,
                           input bit mid_start, input bit sod);
    int d0, r0, t0, rs0, c0, t;
    bit got_done = 0;
    loopback = lb;
    d0 = done_cnt; r0 = rxv_cnt; t0 = txr_cnt; rs0 = rise_cnt; c0 = cs_low_cnt;
    start_pulse(CW'(n));
    for (int i = 0; i < n; i++) begin
      if (i == gap_word) begin
        t = 0;
        while (rxv_cnt < r0 + i && t < 5000) begin @(posedge clk); #1; t++; end
        repeat (gap) @(posedge clk);
        #1;
      end
      send_word(tx_words[i], lb ? tx_words[i] : slave_words[i]);
      if (i == 0 && mid_start) begin
        start_pulse(CW'(7));
        hif.i_num_words = '0;
      end
    end
    t = 0;
    while (t < 5000) begin
      @(posedge clk); #1;
      if (hif.o_done) begin got_done = 1; break; end
      t++;
    end
    chk("done_seen", 32'(got_done), 32'd1);
    if (sod) begin
      start_pulse(CW'(1));
      chk("start_on_done_busy", 32'(hif.o_busy), 32'd0);
      chk("start_on_done_cs", 32'(cs), 32'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("frame_done_cnt", done_cnt - d0, 32'd1);
    chk("frame_rx_cnt", rxv_cnt - r0, 32'(n));
    chk("frame_tx_ready_cnt", txr_cnt - t0, 32'(n));
    chk("frame_sck_rises", rise_cnt - rs0, 32'(WB * n));
    if (gap_word < 0)
      chk("frame_cs_low_cycles", cs_low_cnt - c0, 32'(n * (1 + 2 * DIV * WB) + DIV));
    chk("frame_idle_busy", 32'(hif.o_busy), 32'd0);
  endtask

  task automatic reset_test();
    int d0, r0, rs0, t;
    loopback = 1'b1;
    d0 = done_cnt; r0 = rxv_cnt; rs0 = rise_cnt;
    start_pulse(CW'(2));
    send_word(32'hC3C3_5A5A, 32'hC3C3_5A5A);
    t = 0;
    while (rise_cnt < rs0 + 10 && t < 2000) begin @(posedge clk); #1; t++; end
    chk("reset_ten_rises", rise_cnt - rs0, 32'd10);
    rst = 1'b1;
    #1;
    chk("midreset_cs", 32'(cs), 32'd1);
    chk("midreset_sck", 32'(sck), 32'd0);
    chk("midreset_din", 32'(din), 32'd0);
    chk("midreset_busy", 32'(hif.o_busy), 32'd0);
    exp_q.delete();
    exp_bit_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midreset_no_done", done_cnt - d0, 32'd0);
    chk("midreset_no_rx", rxv_cnt - r0, 32'd0);
  endtask

  task automatic run_div3();
    int t = 0;
    bit ok = 0;
    cs3_low = 0;
    exp3_q.push_back(32'h1234_5678);
    hif3.i_start = 1'b1;
    hif3.i_num_words = CW'(1);
    @(posedge clk); #1;
    hif3.i_start = 1'b0;
    hif3.i_tx_data = $urandom;
    hif3.i_tx_valid = 1'b1;
    while (t < 1000) begin
      @(negedge clk);
      if (hif3.o_tx_ready) begin ok = 1; break; end
      t++;
    end
    chk("div3_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    hif3.i_tx_valid = 1'b0;
    ok = 0; t = 0;
    while (t < 2000) begin
      @(posedge clk); #1;
      if (hif3.o_done) begin ok = 1; break; end
      t++;
    end
    chk("div3_done", 32'(ok), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("div3_rx_drained", exp3_q.size(), 32'd0);
    chk("div3_cs_low_cycles", cs3_low, 32'(1 + 2 * DIV3 * WB + DIV3));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, gw;
    int c0;
    hif.i_start = 1'b0; hif.i_num_words = '0; hif.i_tx_data = '0; hif.i_tx_valid = 1'b1;
    hif3.i_start = 1'b0; hif3.i_num_words = '0; hif3.i_tx_data = '0; hif3.i_tx_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin slave_words[i] = '0; tx_words[i] = '0; end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cs", 32'(cs), 32'd1);
    chk("reset_sck", 32'(sck), 32'd0);
    chk("reset_din", 32'(din), 32'd0);
    chk("reset_busy", 32'(hif.o_busy), 32'd0);
    chk("reset_done", 32'(hif.o_done), 32'd0);
    chk("reset_rx_valid", 32'(hif.o_rx_valid), 32'd0);
    chk("reset_tx_ready", 32'(hif.o_tx_ready), 32'd0);
    chk("reset_rx_data", hif.o_rx_data, 32'd0);
    hif.i_tx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    c0 = cs_low_cnt;
    start_pulse(CW'(0));
    repeat (5) @(posedge clk);
    #1;
    chk("zero_start_busy", 32'(hif.o_busy), 32'd0);
    chk("zero_start_cs", 32'(cs), 32'd1);
    chk("zero_start_cs_cycles", cs_low_cnt - c0, 32'd0);

    tx_words[0] = 32'hA5A5_0F0F;
    run_frame(1, 1'b1, -1, 0, 1'b0, 1'b0);

    tx_words[0] = 32'h0000_0001; tx_words[1] = 32'h8000_0000; tx_words[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) slave_words[i] = 32'hDEAD_BEEF;
    run_frame(3, 1'b0, -1, 0, 1'b1, 1'b1);

    tx_words[0] = $urandom; tx_words[1] = $urandom;
    run_frame(2, 1'b1, 1, 20, 1'b0, 1'b0);

    reset_test();
    tx_words[0] = $urandom;
    run_frame(1, 1'b1, -1, 0, 1'b0, 1'b0);

    run_div3();

    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin tx_words[i] = $urandom; slave_words[i] = $urandom; end
      gw = (n > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, n - 1)) : -1;
      run_frame(n, 1'($urandom_range(0, 1)), gw, $urandom_range(5, 25),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    chk("final_rx_queue_empty", exp_q.size(), 32'd0);
    chk("final_bit_queue_empty", exp_bit_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    checks++; errors++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
